// File: rtl/dct_pkg.sv
// ============================================================================
// Module : dct_pkg
// Desc   : Shared constants and state encoding for the DCT coefficient path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dct_pkg;

  localparam int DCT_BLK_COEFFS = 64;
  localparam int DCT_IDX_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    ZTOK = 2'd2
  } enc_state_t;

endpackage

`default_nettype wire

// File: rtl/priority_encoder_64x6.sv
// ============================================================================
// Module : priority_encoder_64x6
// Desc   : Lowest-set-bit priority encoder with any/single-bit flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module priority_encoder_64x6 #(
  parameter  int W     = 64,
  localparam int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     i_mask,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any_set,
  output logic             o_single_set
);

  // Scan downward so the lowest set bit is the final assignment.
  always_comb begin
    o_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end

  assign o_any_set    = |i_mask;
  assign o_single_set = o_any_set && ((i_mask & (i_mask - W'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/coeff_index_encoder.sv
// ============================================================================
// Module : coeff_index_encoder
// Desc   : Serialises a per-block coefficient mask into ascending 6-bit
//          indices over valid/ready. Optional macro: ZERO_MASK_TOKEN_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module coeff_index_encoder
  import dct_pkg::*;
#(
  parameter  int W     = DCT_BLK_COEFFS,
  localparam int IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_empty,
  output logic             busy
);

  enc_state_t       r_state;
  enc_state_t       w_state_nxt;
  logic [W-1:0]     r_mask;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_single;
  logic             w_accept;
  logic             w_pop;

  priority_encoder_64x6 #(
    .W (W)
  ) u_penc (
    .i_mask       (r_mask),
    .o_idx        (w_idx),
    .o_any_set    (w_any),
    .o_single_set (w_single)
  );

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_pop    = out_ready && (r_state == EMIT);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_idx     = '0;
    out_last    = 1'b0;
    out_empty   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (|in_mask) begin
            w_state_nxt = EMIT;
          end else begin
`ifdef ZERO_MASK_TOKEN_EN
            w_state_nxt = ZTOK;
`else
            w_state_nxt = IDLE;
`endif
          end
        end
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = w_any;
        out_idx   = w_idx;
        out_last  = w_single;
        if (out_ready && w_single) begin
          w_state_nxt = IDLE;
        end
      end
`ifdef ZERO_MASK_TOKEN_EN
      ZTOK: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_empty = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mask <= in_mask;
      end else if (w_pop) begin
        // Clearing the lowest set bit advances to the next index.
        r_mask <= r_mask & (r_mask - W'(1));
      end
    end
  end

endmodule

`default_nettype wire
